// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Fetch PC owner; advances, holds or redirects each cycle and
//            drives IF/ID and ID/EX stall/flush/bubble controls.
// Revision : 1.0
// ============================================================================
module pc_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0040_0000),
    parameter int                MAX_WAIT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              ex_is_load,
    input  logic [4:0]        ex_rd,
    input  logic              ex_redirect,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic              pc_stall,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              fetch_timeout,
    output logic [15:0]       stall_count,
    output logic [15:0]       redirect_count
);

    localparam logic [7:0]  c_max_wait = 8'(MAX_WAIT);
    localparam logic [15:0] c_cnt_max  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LU_HOLD   = 2'd1,
        ST_IMEM_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_wait_cnt;
    logic              r_timeout;
    logic [15:0]       r_stall_cnt;
    logic [15:0]       r_redirect_cnt;

    logic              w_hz;
    logic              w_lu_stall;
    logic              w_stall;
    logic              w_flush;
    logic              w_bubble;
    logic [7:0]        w_wait_next;
    logic [ADDR_W-1:0] w_target;

    assign w_hz = ex_is_load && (ex_rd != 5'd0) &&
                  ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                   (id_uses_rs2 && (id_rs2 == ex_rd)));

    // Hazard only counts in RUN; LU_HOLD skips it so each load bubbles once.
    assign w_lu_stall  = (r_state == ST_RUN) && w_hz && !ex_redirect;
    assign w_target    = {ex_target[ADDR_W-1:2], 2'b00};
    assign w_wait_next = (r_wait_cnt == c_max_wait) ? r_wait_cnt : r_wait_cnt + 8'd1;

    always_comb begin
        w_stall  = 1'b0;
        w_flush  = 1'b0;
        w_bubble = 1'b0;
        if (reset) begin
            w_stall  = 1'b0;
        end else if (ex_redirect) begin
            w_flush  = 1'b1;
            w_bubble = 1'b1;
        end else if (w_lu_stall) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
        end else if (!imem_ready) begin
            w_stall  = 1'b1;
            w_flush  = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= ST_RUN;
            r_pc           <= RESET_PC;
            r_wait_cnt     <= 8'd0;
            r_timeout      <= 1'b0;
            r_stall_cnt    <= 16'd0;
            r_redirect_cnt <= 16'd0;
        end else begin
            if (ex_redirect) begin
                r_pc       <= w_target;
                r_state    <= ST_RUN;
                r_wait_cnt <= 8'd0;
                if (r_redirect_cnt != c_cnt_max) begin
                    r_redirect_cnt <= r_redirect_cnt + 16'd1;
                end
            end else if (w_lu_stall) begin
                r_state <= ST_LU_HOLD;
            end else if (!imem_ready) begin
                r_state    <= ST_IMEM_WAIT;
                r_wait_cnt <= w_wait_next;
                if (w_wait_next == c_max_wait) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_pc       <= r_pc + ADDR_W'(4);
                r_state    <= ST_RUN;
                r_wait_cnt <= 8'd0;
            end

            if (w_stall && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign pc_out         = r_pc;
    assign pc_stall       = w_stall;
    assign if_id_flush    = w_flush;
    assign id_ex_bubble   = w_bubble;
    assign fetch_timeout  = r_timeout;
    assign stall_count    = r_stall_cnt;
    assign redirect_count = r_redirect_cnt;

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Pipeline front-end controller that owns the fetch program counter and decides each cycle whether it advances, holds, or redirects.
- Detects load-use hazards between ID and EX, applies taken-branch/jump redirects resolved in EX, and holds fetch while instruction memory is not ready.
- Drives the stall/flush/bubble controls for the IF/ID and ID/EX pipeline registers.
- Keeps saturating stall and redirect counters and a sticky fetch-timeout flag for debug.

Parameters:
ADDR_W, 32, width of the program counter and branch target
RESET_PC, 32'h0040_0000, first fetch address after reset
MAX_WAIT, 15, consecutive imem-not-ready cycles before fetch_timeout sets (1..255)

Ports:
clock  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
id_rs1  input  5  source register 1 of instruction in ID
id_rs2  input  5  source register 2 of instruction in ID
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
ex_is_load  input  1  instruction in EX is a load
ex_rd  input  5  destination register of EX instruction
ex_redirect  input  1  EX resolved a taken branch or jump
ex_target  input  ADDR_W  redirect address from EX
imem_ready  input  1  instruction memory returned valid data for pc_out this cycle
pc_out  output  ADDR_W  current fetch address (registered)
pc_stall  output  1  fetch holds this cycle
if_id_flush  output  1  IF/ID loads a bubble at next edge
id_ex_bubble  output  1  ID/EX loads a bubble and IF/ID holds its contents
fetch_timeout  output  1  sticky; imem stuck not-ready for MAX_WAIT cycles
stall_count  output  16  saturating count of cycles with pc_stall=1
redirect_count  output  16  saturating count of accepted redirects

Behaviour:
- Reset (async) values:
  - pc_out=RESET_PC, state=RUN, wait counter=0.
  - fetch_timeout=0, stall_count=0, redirect_count=0.
  - Combinational outputs are 0 while reset is high.
- States: RUN, LU_HOLD, IMEM_WAIT. The state register and counters are registered; pc_stall, if_id_flush and id_ex_bubble are combinational from state and inputs.
- Hazard term: hz = ex_is_load & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority each cycle, highest first: ex_redirect > hz (only in RUN) > !imem_ready > advance.
- Redirect (any state):
  - pc_out <= {ex_target[ADDR_W-1:2],2'b00}; the low 2 bits are forced to zero.
  - if_id_flush=1, id_ex_bubble=1, pc_stall=0.
  - redirect_count++.
  - Next state is RUN and the wait counter clears. Any simultaneous hz is ignored because the ID instruction is squashed.
- Load-use, in RUN when hz=1 and ex_redirect=0:
  - pc_stall=1, id_ex_bubble=1, pc_out holds.
  - Next state is LU_HOLD.
- LU_HOLD: lasts exactly one cycle and hz is not evaluated. It then behaves like RUN without the hazard check and returns to RUN (or goes to IMEM_WAIT if imem_ready=0). This guarantees at most one load-use bubble per load.
- Imem not ready, with no redirect and no hz:
  - pc_stall=1, if_id_flush=1, pc_out holds.
  - State becomes IMEM_WAIT and the wait counter increments, saturating at MAX_WAIT.
  - When the counter reaches MAX_WAIT, fetch_timeout <= 1. It stays set until reset.
- IMEM_WAIT exits when imem_ready=1: pc_out <= pc_out+4, counter clears, next state is RUN.
- Advance, in RUN or LU_HOLD with imem_ready=1: pc_out <= pc_out+4. PC arithmetic is modulo 2^ADDR_W, so 32'hFFFF_FFFC wraps to 0.
- stall_count increments on every edge where pc_stall=1. Both counters saturate at 16'hFFFF and never wrap.
- Reset asserted mid-stall or mid-wait returns to reset values immediately. The first fetch after release is RESET_PC.

Test Plan:
- Reset release, imem_ready=1 constant, 3 edges -> pc_out 0x00400000, 0x00400004, 0x00400008, 0x0040000C; all control outputs 0.
- ex_is_load=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 at pc 0x00400008:
  - pc_stall=1 and id_ex_bubble=1 for exactly one cycle; pc holds 0x00400008 and then advances to 0x0040000C.
  - Repeat with ex_rd=0 -> no stall.
- ex_redirect=1, ex_target=0x00400103 in the same cycle as a load-use hazard:
  - if_id_flush=1, id_ex_bubble=1, pc_stall=0.
  - Next pc_out=0x00400100; redirect_count=1.
- imem_ready=0 for 4 cycles, then 1:
  - pc holds 4 cycles with pc_stall=1 and if_id_flush=1; stall_count=4.
  - pc then advances by 4; fetch_timeout stays 0.
- imem_ready=0 for 20 cycles -> fetch_timeout=1 after the 15th not-ready cycle; it stays 1 after imem_ready=1 and clears only on reset.
- Redirect during IMEM_WAIT to 0x00400200 -> pc_out=0x00400200 next edge, wait counter cleared; reset pulse mid-wait -> pc_out=0x00400000 asynchronously.
